// File: rtl/tpu_pkg.sv
// Shared types and defaults for the TPU tile sequencer.
//   seq_state_t : tile sequencer FSM states.
//   DEF_DATA_W  : default fixed-point element width.
//   DEF_ADDR_W  : default unified-buffer address width.
package tpu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DONE
  } seq_state_t;

endpackage

// File: rtl/tpu_deskew.sv
// Per-column deskew for the systolic array bottom row.
// Column j is delayed by (N-1-j) cycles so that all columns of one logical
// row line up, then every column is registered once.
//   clk, rst    : clock, synchronous active-high reset (valids only)
//   col_data    : staggered column data, column j at [j*DATA_W +: DATA_W]
//   col_vld     : per-column valid
//   row_data_p1 : aligned row data (unreset datapath)
//   row_vld_p1  : aligned per-column valid
module tpu_deskew
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*DATA_W-1:0] col_data,
  input  logic [N-1:0]        col_vld,
  output logic [N*DATA_W-1:0] row_data_p1,
  output logic [N-1:0]        row_vld_p1
);

  logic [N*DATA_W-1:0] data_p0;
  logic [N-1:0]        vld_p0;

  // Stage p0: per-column skew delay lines
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_direct
      assign data_p0[j*DATA_W +: DATA_W] = col_data[j*DATA_W +: DATA_W];
      assign vld_p0[j]                   = col_vld[j];
    end else begin : g_dly
      logic [DATA_W-1:0] dly_data [D];
      logic [D-1:0]      dly_vld;

      always_ff @(posedge clk) begin
        dly_data[0] <= col_data[j*DATA_W +: DATA_W];
        for (int k = 1; k < D; k++) begin
          dly_data[k] <= dly_data[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dly_vld <= '0;
        end else begin
          dly_vld[0] <= col_vld[j];
          for (int k = 1; k < D; k++) begin
            dly_vld[k] <= dly_vld[k-1];
          end
        end
      end

      assign data_p0[j*DATA_W +: DATA_W] = dly_data[D-1];
      assign vld_p0[j]                   = dly_vld[D-1];
    end
  end

  // Stage p1: common output register for all columns
  always_ff @(posedge clk) begin
    row_data_p1 <= data_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_vld_p1 <= '0;
    end else begin
      row_vld_p1 <= vld_p0;
    end
  end

endmodule

// File: rtl/tpu_tile_seq.sv
// N x N tile sequencer between the unified buffer (UB) and a systolic array.
// Accepts one matmul tile command, issues the weight read, waits for the
// weights to settle, pulses the shadow-to-active switch, starts input
// streaming, then deskews the column outputs into rows and writes each row
// back to the UB at consecutive addresses.
//   clk, rst               : clock, synchronous active-high reset
//   cmd_*                  : tile command (valid/ready, base addresses, rows)
//   rd_weight_start_out    : one-cycle weight read request, addr latched
//   rd_input_start_out     : one-cycle input read request, addr/loc latched
//   sys_switch_out         : one-cycle weight switch pulse
//   sys_data_in/valid_in   : staggered systolic bottom-row outputs
//   ub_wr_*                : row writeback beat
//   busy_out, done_out     : status, done is a one-cycle pulse
//   err_out                : sticky deskew misalignment flag
module tpu_tile_seq
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ROWS_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_in,
  output logic                cmd_ready_out,
  input  logic [ROWS_W-1:0]   cmd_w_addr_in,
  input  logic [ROWS_W-1:0]   cmd_x_addr_in,
  input  logic [ADDR_W-1:0]   cmd_y_addr_in,
  input  logic [ROWS_W-1:0]   cmd_rows_in,
  output logic                rd_weight_start_out,
  output logic [ROWS_W-1:0]   rd_weight_addr_out,
  output logic                rd_input_start_out,
  output logic [ROWS_W-1:0]   rd_input_addr_out,
  output logic [ROWS_W-1:0]   rd_input_loc_out,
  output logic                sys_switch_out,
  input  logic [N*DATA_W-1:0] sys_data_in,
  input  logic [N-1:0]        sys_valid_in,
  output logic [ADDR_W-1:0]   ub_wr_addr_out,
  output logic                ub_wr_addr_valid_out,
  output logic [N*DATA_W-1:0] ub_wr_data_out,
  output logic [N-1:0]        ub_wr_valid_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                err_out
);

  // Weight load wait covers N weight rows plus N cycles of column skew.
  localparam int              CNT_W     = $clog2(2*N + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(2*N - 1);

  seq_state_t state_q, state_d;

  logic [ROWS_W-1:0]   w_addr_q;
  logic [ROWS_W-1:0]   x_addr_q;
  logic [ROWS_W-1:0]   rows_q;
  logic [ROWS_W-1:0]   row_idx_q;
  logic [ADDR_W-1:0]   y_addr_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                in_first_q;
  logic                err_q;

  logic [N*DATA_W-1:0] row_data_p1;
  logic [N-1:0]        row_vld_p1;

  logic                accept;
  logic                beat;
  logic                misalign;
  logic                last_beat;

  tpu_deskew #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_deskew (
    .clk         (clk),
    .rst         (rst),
    .col_data    (sys_data_in),
    .col_vld     (sys_valid_in),
    .row_data_p1 (row_data_p1),
    .row_vld_p1  (row_vld_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    accept               = 1'b0;
    beat                 = 1'b0;
    misalign             = 1'b0;
    last_beat            = (row_idx_q == rows_q - ROWS_W'(1));
    cmd_ready_out        = 1'b0;
    busy_out             = 1'b1;
    done_out             = 1'b0;
    rd_weight_start_out  = 1'b0;
    rd_input_start_out   = 1'b0;
    sys_switch_out       = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_out = 1'b1;
        busy_out      = 1'b0;
        if (cmd_valid_in) begin
          accept  = 1'b1;
          state_d = (cmd_rows_in == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        rd_weight_start_out = (wait_cnt_q == '0);
        if (wait_cnt_q == LOAD_LAST) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        sys_switch_out = 1'b1;
        state_d        = STREAM;
      end
      STREAM: begin
        rd_input_start_out = in_first_q;
        // A partial row means the columns drifted apart: drop it, flag it.
        if (row_vld_p1 == '1) begin
          beat = 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end else if (row_vld_p1 != '0) begin
          misalign = 1'b1;
        end
      end
      DONE: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_q   <= '0;
      x_addr_q   <= '0;
      rows_q     <= '0;
      y_addr_q   <= '0;
      row_idx_q  <= '0;
      wait_cnt_q <= '0;
      in_first_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Marks the first STREAM cycle for the input read pulse.
      in_first_q <= (state_q == SWITCH);
      if (accept) begin
        w_addr_q   <= cmd_w_addr_in;
        x_addr_q   <= cmd_x_addr_in;
        rows_q     <= cmd_rows_in;
        y_addr_q   <= cmd_y_addr_in;
        row_idx_q  <= '0;
        wait_cnt_q <= '0;
      end
      if (state_q == LOAD_W) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
      if (beat) begin
        row_idx_q <= row_idx_q + ROWS_W'(1);
      end
      if (misalign) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rd_weight_addr_out   = w_addr_q;
  assign rd_input_addr_out    = x_addr_q;
  assign rd_input_loc_out     = rows_q;
  assign err_out              = err_q;

  // Address wraps modulo 2^ADDR_W; outputs stay quiet between beats.
  assign ub_wr_addr_valid_out = beat;
  assign ub_wr_valid_out      = {N{beat}};
  assign ub_wr_addr_out       = beat ? (y_addr_q + ADDR_W'(row_idx_q)) : '0;
  assign ub_wr_data_out       = beat ? row_data_p1 : '0;

endmodule

// File: tb/tb_tpu_tile_seq.sv
// Directed bench for tpu_tile_seq with N=2, DATA_W=16, ADDR_W=16, ROWS_W=6.
module tb_tpu_tile_seq;

  localparam int N      = 2;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int ROWS_W = 6;

  logic                clk;
  logic                rst;
  logic                cmd_valid_in;
  logic                cmd_ready_out;
  logic [ROWS_W-1:0]   cmd_w_addr_in;
  logic [ROWS_W-1:0]   cmd_x_addr_in;
  logic [ADDR_W-1:0]   cmd_y_addr_in;
  logic [ROWS_W-1:0]   cmd_rows_in;
  logic                rd_weight_start_out;
  logic [ROWS_W-1:0]   rd_weight_addr_out;
  logic                rd_input_start_out;
  logic [ROWS_W-1:0]   rd_input_addr_out;
  logic [ROWS_W-1:0]   rd_input_loc_out;
  logic                sys_switch_out;
  logic [N*DATA_W-1:0] sys_data_in;
  logic [N-1:0]        sys_valid_in;
  logic [ADDR_W-1:0]   ub_wr_addr_out;
  logic                ub_wr_addr_valid_out;
  logic [N*DATA_W-1:0] ub_wr_data_out;
  logic [N-1:0]        ub_wr_valid_out;
  logic                busy_out;
  logic                done_out;
  logic                err_out;

  int errors = 0;
  int checks = 0;

  tpu_tile_seq #(
    .N      (N),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ROWS_W (ROWS_W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_valid_in         (cmd_valid_in),
    .cmd_ready_out        (cmd_ready_out),
    .cmd_w_addr_in        (cmd_w_addr_in),
    .cmd_x_addr_in        (cmd_x_addr_in),
    .cmd_y_addr_in        (cmd_y_addr_in),
    .cmd_rows_in          (cmd_rows_in),
    .rd_weight_start_out  (rd_weight_start_out),
    .rd_weight_addr_out   (rd_weight_addr_out),
    .rd_input_start_out   (rd_input_start_out),
    .rd_input_addr_out    (rd_input_addr_out),
    .rd_input_loc_out     (rd_input_loc_out),
    .sys_switch_out       (sys_switch_out),
    .sys_data_in          (sys_data_in),
    .sys_valid_in         (sys_valid_in),
    .ub_wr_addr_out       (ub_wr_addr_out),
    .ub_wr_addr_valid_out (ub_wr_addr_valid_out),
    .ub_wr_data_out       (ub_wr_data_out),
    .ub_wr_valid_out      (ub_wr_valid_out),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .err_out              (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; afterwards we sit 2 time units into the new cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [ROWS_W-1:0] w, input logic [ROWS_W-1:0] x,
                     input logic [ADDR_W-1:0] y, input logic [ROWS_W-1:0] r);
    cmd_valid_in  = 1'b1;
    cmd_w_addr_in = w;
    cmd_x_addr_in = x;
    cmd_y_addr_in = y;
    cmd_rows_in   = r;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [15:0] d1, input logic [15:0] d0);
    sys_valid_in = v;
    sys_data_in  = {d1, d0};
  endtask

  initial begin
    rst           = 1'b1;
    cmd_valid_in  = 1'b0;
    cmd_w_addr_in = '0;
    cmd_x_addr_in = '0;
    cmd_y_addr_in = '0;
    cmd_rows_in   = '0;
    sys_valid_in  = '0;
    sys_data_in   = '0;

    // Reset values
    step();
    step();
    chk("rst_ready", cmd_ready_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_wr_addr_valid", ub_wr_addr_valid_out, 0);
    chk("rst_wr_valid", ub_wr_valid_out, 0);
    chk("rst_wr_data", ub_wr_data_out, 0);
    chk("rst_wr_addr", ub_wr_addr_out, 0);
    chk("rst_rd_w_start", rd_weight_start_out, 0);
    chk("rst_rd_w_addr", rd_weight_addr_out, 0);
    chk("rst_rd_in_start", rd_input_start_out, 0);
    chk("rst_switch", sys_switch_out, 0);
    rst = 1'b0;
    step();

    // Normal tile: w=4 x=0 y=16 rows=2, accepted at T
    cmd(6'd4, 6'd0, 16'd16, 6'd2);
    chk("t1_ready_at_T", cmd_ready_out, 1);
    step(); // T+1
    cmd_valid_in = 1'b0;
    chk("t1_rd_w_start", rd_weight_start_out, 1);
    chk("t1_rd_w_addr", rd_weight_addr_out, 4);
    chk("t1_busy", busy_out, 1);
    chk("t1_not_ready", cmd_ready_out, 0);
    step(); // T+2
    chk("t1_rd_w_start_once", rd_weight_start_out, 0);
    step(); // T+3
    step(); // T+4
    chk("t1_switch_early", sys_switch_out, 0);
    step(); // T+5
    chk("t1_switch", sys_switch_out, 1);
    chk("t1_in_start_early", rd_input_start_out, 0);
    step(); // T+6
    chk("t1_in_start", rd_input_start_out, 1);
    chk("t1_in_addr", rd_input_addr_out, 0);
    chk("t1_in_loc", rd_input_loc_out, 2);
    chk("t1_switch_once", sys_switch_out, 0);
    step(); // c
    chk("t1_in_start_once", rd_input_start_out, 0);
    drive(2'b01, 16'h0000, 16'h0011);
    step(); // c+1
    chk("t1_no_write_c1", ub_wr_addr_valid_out, 0);
    drive(2'b11, 16'h0012, 16'h0021);
    step(); // c+2
    chk("t1_beat0_valid", ub_wr_addr_valid_out, 1);
    chk("t1_beat0_addr", ub_wr_addr_out, 16);
    chk("t1_beat0_data", ub_wr_data_out, 32'h0012_0011);
    chk("t1_beat0_wr_valid", ub_wr_valid_out, 2'b11);
    drive(2'b10, 16'h0022, 16'h0000);
    step(); // c+3
    chk("t1_beat1_valid", ub_wr_addr_valid_out, 1);
    chk("t1_beat1_addr", ub_wr_addr_out, 17);
    chk("t1_beat1_data", ub_wr_data_out, 32'h0022_0021);
    chk("t1_done_early", done_out, 0);
    drive(2'b00, 16'h0000, 16'h0000);
    step(); // c+4
    chk("t1_done", done_out, 1);
    chk("t1_no_write_done", ub_wr_addr_valid_out, 0);
    step(); // c+5
    chk("t1_done_once", done_out, 0);
    chk("t1_idle_ready", cmd_ready_out, 1);
    chk("t1_idle_busy", busy_out, 0);
    chk("t1_err_clear", err_out, 0);

    // Zero-row command
    cmd(6'd7, 6'd3, 16'd5, 6'd0);
    step(); // T+1
    cmd_valid_in = 1'b0;
    chk("t2_done", done_out, 1);
    chk("t2_no_rd_w", rd_weight_start_out, 0);
    chk("t2_no_switch", sys_switch_out, 0);
    chk("t2_no_write", ub_wr_addr_valid_out, 0);
    chk("t2_busy", busy_out, 1);
    step(); // T+2
    chk("t2_idle", cmd_ready_out, 1);
    chk("t2_done_once", done_out, 0);
    chk("t2_no_rd_w2", rd_weight_start_out, 0);
    chk("t2_no_rd_in", rd_input_start_out, 0);

    // Misaligned row 0, then reset mid-STREAM
    cmd(6'd1, 6'd2, 16'd32, 6'd2);
    step(); // T+1
    cmd_valid_in = 1'b0;
    step();
    step();
    step();
    step();
    step(); // T+6
    chk("t3_in_start", rd_input_start_out, 1);
    chk("t3_in_addr", rd_input_addr_out, 2);
    step(); // c
    drive(2'b01, 16'h0000, 16'h00A0);
    step(); // c+1
    drive(2'b00, 16'h0000, 16'h0000);
    step(); // c+2: only col0 aligned
    chk("t3_drop_c2", ub_wr_addr_valid_out, 0);
    chk("t3_err_pre", err_out, 0);
    drive(2'b10, 16'h00B0, 16'h0000);
    step(); // c+3: only col1 aligned
    chk("t3_err_set", err_out, 1);
    chk("t3_drop_c3", ub_wr_addr_valid_out, 0);
    drive(2'b01, 16'h0000, 16'h00A1);
    step(); // c+4
    chk("t3_err_sticky", err_out, 1);
    chk("t3_drop_c4", ub_wr_addr_valid_out, 0);
    drive(2'b10, 16'h00B1, 16'h0000);
    step(); // c+5
    chk("t3_row1_valid", ub_wr_addr_valid_out, 1);
    chk("t3_row1_addr", ub_wr_addr_out, 32);
    chk("t3_row1_data", ub_wr_data_out, 32'h00B1_00A1);
    drive(2'b00, 16'h0000, 16'h0000);
    step(); // c+6
    chk("t3_still_busy", busy_out, 1);
    chk("t3_no_done", done_out, 0);
    chk("t3_no_write_c6", ub_wr_addr_valid_out, 0);
    rst = 1'b1;
    drive(2'b11, 16'h5555, 16'hAAAA);
    step(); // c+7, reset edge taken
    chk("t3_rst_ready", cmd_ready_out, 1);
    chk("t3_rst_busy", busy_out, 0);
    chk("t3_rst_err", err_out, 0);
    chk("t3_rst_wr_valid", ub_wr_addr_valid_out, 0);
    chk("t3_rst_wr_data", ub_wr_data_out, 0);
    chk("t3_rst_done", done_out, 0);
    rst = 1'b0;
    step(); // c+8
    chk("t3_post_rst_nowr0", ub_wr_addr_valid_out, 0);
    step(); // c+9
    chk("t3_post_rst_nowr1", ub_wr_addr_valid_out, 0);
    chk("t3_post_rst_err", err_out, 0);
    drive(2'b00, 16'h0000, 16'h0000);
    step();
    chk("t3_post_rst_nowr2", ub_wr_addr_valid_out, 0);

    // Address wrap with cmd_valid held through the whole tile
    cmd(6'd3, 6'd1, 16'hFFFF, 6'd2);
    step(); // T+1
    chk("t4_rd_w_start", rd_weight_start_out, 1);
    chk("t4_rd_w_addr", rd_weight_addr_out, 3);
    step(); // T+2
    chk("t4_not_ready", cmd_ready_out, 0);
    chk("t4_rd_w_once", rd_weight_start_out, 0);
    drive(2'b11, 16'hDEAD, 16'hBEEF);
    step(); // T+3: stray valids during LOAD_W
    drive(2'b00, 16'h0000, 16'h0000);
    chk("t4_stray_nowr", ub_wr_addr_valid_out, 0);
    chk("t4_rd_w_none", rd_weight_start_out, 0);
    step(); // T+4
    chk("t4_stray_noerr", err_out, 0);
    chk("t4_stray_nowr2", ub_wr_addr_valid_out, 0);
    step(); // T+5
    chk("t4_switch", sys_switch_out, 1);
    step(); // T+6
    chk("t4_in_start", rd_input_start_out, 1);
    chk("t4_in_loc", rd_input_loc_out, 2);
    chk("t4_in_addr", rd_input_addr_out, 1);
    step(); // c
    drive(2'b01, 16'h0000, 16'h0001);
    step(); // c+1
    drive(2'b11, 16'h0002, 16'h0003);
    step(); // c+2
    chk("t4_beat0_addr", ub_wr_addr_out, 16'hFFFF);
    chk("t4_beat0_data", ub_wr_data_out, 32'h0002_0001);
    chk("t4_beat0_valid", ub_wr_addr_valid_out, 1);
    drive(2'b10, 16'h0004, 16'h0000);
    step(); // c+3
    chk("t4_beat1_addr", ub_wr_addr_out, 16'h0000);
    chk("t4_beat1_data", ub_wr_data_out, 32'h0004_0003);
    chk("t4_beat1_valid", ub_wr_addr_valid_out, 1);
    drive(2'b00, 16'h0000, 16'h0000);
    step(); // c+4
    chk("t4_done", done_out, 1);
    chk("t4_done_not_ready", cmd_ready_out, 0);
    cmd_valid_in = 1'b0;
    step(); // c+5
    chk("t4_idle_busy", busy_out, 0);
    chk("t4_idle_ready", cmd_ready_out, 1);
    step(); // c+6
    chk("t4_single_accept", busy_out, 0);
    chk("t4_no_rd_w", rd_weight_start_out, 0);
    chk("t4_err_clear", err_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout observed=stalled expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tpu_tile_seq.md
Name: tpu_tile_seq

Overview:
Parametrised N×N tile sequencer: the next-generation controller between the unified buffer and an N×N systolic array. It accepts one matmul tile command and sequences the weight load, the shadow-to-active weight switch, and input streaming. It then deskews the staggered systolic column outputs into whole rows and writes each row back to the UB at consecutive addresses. This replaces host-driven start and switch strobes with a single command/done handshake.

Parameters:
N, 2, systolic array dimension (rows = columns = channels)
DATA_W, 16, fixed-point element width
ADDR_W, 16, UB address width
ROWS_W, 6, width of the row-count and read-address fields

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid_in  in  1  tile command valid
cmd_ready_out  out  1  high only in IDLE
cmd_w_addr_in  in  ROWS_W  UB weight base address
cmd_x_addr_in  in  ROWS_W  UB input base address
cmd_y_addr_in  in  ADDR_W  UB writeback base address
cmd_rows_in  in  ROWS_W  number of input rows (0 legal)
rd_weight_start_out  out  1  one-cycle weight read pulse
rd_weight_addr_out  out  ROWS_W  latched weight address
rd_input_start_out  out  1  one-cycle input read pulse
rd_input_addr_out  out  ROWS_W  latched input address
rd_input_loc_out  out  ROWS_W  latched row count
sys_switch_out  out  1  one-cycle weight switch pulse
sys_data_in  in  N*DATA_W  systolic bottom-row outputs; column j at [j*DATA_W +: DATA_W]
sys_valid_in  in  N  per-column valid
ub_wr_addr_out  out  ADDR_W  writeback address
ub_wr_addr_valid_out  out  1  writeback beat
ub_wr_data_out  out  N*DATA_W  deskewed row
ub_wr_valid_out  out  N  per-column write valid (all ones on a beat)
busy_out  out  1  not IDLE
done_out  out  1  one-cycle tile-complete pulse
err_out  out  1  sticky deskew misalignment flag

Behaviour:
- One clock domain. rst is synchronous and active-high.
- On reset, every output is 0 except cmd_ready_out=1. Reset puts the FSM in IDLE, clears counters, deskew pipes and err_out. It takes effect mid-operation with no trailing writes.
- FSM states: IDLE, LOAD_W, SWITCH, STREAM, DONE.
- Accept happens at cycle T when cmd_valid_in && cmd_ready_out. Addresses and rows are latched at T.
  - If rows==0: go to DONE. done_out=1 at T+1. No reads, switch or writes are issued. Back to IDLE at T+2.
  - Otherwise: go to LOAD_W.
- LOAD_W runs cycles T+1..T+2N.
  - rd_weight_start_out=1 at T+1 only.
  - A counter waits 2N cycles total, covering N weight rows plus the column skew.
- SWITCH: sys_switch_out=1 at T+2N+1.
- STREAM starts at T+2N+2 with rd_input_start_out=1 for that cycle only.
  - The FSM stays in STREAM until rows writeback beats have issued.
  - There is no timeout.
- Deskew:
  - Column j data and valid pass through a shift delay of (N-1-j) cycles. Column N-1 has zero delay.
  - All columns are then registered once. Total latency is 1 cycle after column N-1 valid arrives.
- Writeback beat: when all N aligned valids are 1, assert ub_wr_addr_valid_out=1 and ub_wr_valid_out=all ones.
  - ub_wr_addr_out = y_addr + row_idx, wrapping modulo 2^ADDR_W.
  - row_idx increments per beat.
- Aligned valids that are non-zero but not all ones: set err_out sticky and drop that beat (no write, row_idx unchanged).
- Valids arriving outside STREAM, or after rows beats: ignored, no write, no error.
- After the final beat, DONE follows. done_out=1 on the cycle after the last beat, then IDLE next cycle.
- cmd_valid_in while busy: not accepted (cmd_ready_out=0). No queueing.
- No arithmetic on data. Data passes through bit-exact.

Decomposition:
- Package tpu_pkg: seq_state_t enum (IDLE, LOAD_W, SWITCH, STREAM, DONE) and DATA_W/ADDR_W defaults.
- One sub-module, tpu_deskew: parametrised per-column delay line (N, DATA_W) returning aligned data and valid.

Test Plan:
- Reset mid-STREAM: rst for 1 cycle → all outputs 0, cmd_ready_out=1, no ub_wr_addr_valid_out afterwards, err_out=0.
- N=2, cmd w=4 x=0 y=16 rows=2, accepted at T → rd_weight_start_out at T+1, sys_switch_out at T+5, rd_input_start_out at T+6 with addr 0 and loc 2.
- Output stimulus: col0 valid at c, c+1 (0x0011, 0x0021); col1 valid at c+1, c+2 (0x0012, 0x0022). Required: write addr 16 data {0x0012,0x0011} at c+2; addr 17 {0x0022,0x0021} at c+3; done_out at c+4.
- rows=0 accepted at T → done_out at T+1, no read, switch or write pulses, IDLE at T+2.
- Misaligned: col1 valid one cycle late for row 0 → err_out=1 sticky, beat dropped, row 1 still written at y+0.
- y=0xFFFF, rows=2 → writes at 0xFFFF then 0x0000. cmd_valid_in held during busy → exactly one command accepted.
